brent_kung_adder32: RTL and testbench
=====================================

// Module: brent_kung_adder32
// PURPOSE
//  - 32-bit two-operand adder with carry-in, built as a Brent-Kung parallel-prefix carry network.
//  - Combinational prefix core followed by an output register stage.
//  - Serves as the adder leaf used inside the recursive Karatsuba multiplier datapath.
// PARAMETERS
//  - None. Width is fixed at 32; the prefix tree is hard-wired for 32 bits.
// PORTS
//  clk    input   1   clock; all state updates on rising edge
//  rst_n  input   1   synchronous active-low reset, sampled on rising clk edge
//  x      input  32   operand A, unsigned
//  y      input  32   operand B, unsigned
//  cin    input   1   carry into bit 0
//  s      output 32   registered sum bits [31:0] of x+y+cin
//  cout   output  1   registered carry out of bit 31
// BEHAVIOUR
//  - Arithmetic: {cout,s} = x + y + cin, exact 33-bit result; no overflow or saturation; wraps mod 2^32 with cout=1.
//  - Pre-processing per bit i: g[i]=x[i]&y[i], p[i]=x[i]^y[i].
//  - cin folded into bit 0: G[0]=g[0]|(p[0]&cin).
//  - Prefix operator (G,P)o(G',P') = (G|(P&G'), P&P').
//  - Up-sweep: 5 levels (span 1,2,4,8,16) producing group terms at indices 2^k-1 and their strided positions.
//  - Down-sweep: 4 levels filling the remaining prefixes.
//  - Total: 9 prefix levels, 57 prefix cells.
//  - Carry c[i+1]=G[i:0]; c[0]=cin; s[i]=p[i]^c[i]; cout=G[31:0].
//  - Registers: s and cout are captured on each rising clk edge when rst_n=1.
//  - Latency: 1 cycle from input sample to output. Throughput: one new operand set every cycle; no handshake, no enable.
//  - Reset: rst_n=0 at a rising edge forces s=32'h0, cout=0. Reset takes priority over new data.
//  - Reset asserted mid-stream discards the in-flight result. The first valid result appears 1 cycle after the first edge with rst_n=1.
//  - X/unknown inputs propagate to outputs. No internal state beyond the output register(s).
//  - Boundary cases:
//    - 32'hFFFFFFFF + 0 + 1: s=0, cout=1 (full carry ripple through all levels).
//    - 0 + 0 + 0: s=0, cout=0.
// CONFIGURATION
//  - Macro BK_INPUT_REG_EN.
//  - Defined: x, y and cin are registered before the prefix core (reset value 0). Total latency is 2 cycles.
//    Both stages reset synchronously on rst_n=0.
//  - Undefined (default): inputs feed the prefix core directly. Latency is 1 cycle.
//  - Arithmetic is identical in both builds; only latency differs.
// TESTING (results checked N cycles after apply; N=1, or 2 with BK_INPUT_REG_EN)
//  - Reset: hold rst_n=0 for 2 edges with random x/y/cin -> s=32'h00000000, cout=0.
//  - x=32'h42884743, y=32'h42884743, cin=0 -> s=32'h85108E86, cout=0.
//  - x=32'hF28A47B3, y=32'h4B8B47A3, cin=1 -> s=32'h3E158F57, cout=1.
//  - x=32'hF28E47BC, y=32'h9B8B47AB, cin=1 -> s=32'h8E198F68, cout=1.
//  - Carry chain:
//    - x=32'hFFFFFFFF, y=0, cin=1 -> s=0, cout=1.
//    - x=32'h7FFFFFFF, y=1, cin=0 -> s=32'h80000000, cout=0.
//  - Pipelining and reset: back-to-back operand change every cycle plus rst_n pulse mid-stream ->
//    each output matches its own inputs at the stated latency; the cycle after the reset edge shows 0.
//  - Random: 10k random x/y/cin vectors compared against the 33-bit reference sum x+y+cin.

Source files
------------

// File: rtl/brent_kung_adder32.sv
// 32-bit Brent-Kung parallel-prefix adder with carry-in and a registered sum/carry-out.
// Optional macro BK_INPUT_REG_EN adds an input register stage (2-cycle latency instead of 1).
module brent_kung_adder32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        cin,
   output logic [31:0] s,
   output logic        cout
);

   localparam int unsigned W = 32;

   logic [W-1:0] core_x;
   logic [W-1:0] core_y;
   logic         core_cin;

`ifdef BK_INPUT_REG_EN
   // Operand capture stage ahead of the prefix core
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         core_x   <= '0;
         core_y   <= '0;
         core_cin <= 1'b0;
      end else begin
         core_x   <= x;
         core_y   <= y;
         core_cin <= cin;
      end
   end
`else
   assign core_x   = x;
   assign core_y   = y;
   assign core_cin = cin;
`endif

   logic [W-1:0] p;
   logic [W:0]   c;

   // Prefix carry network: 5 up-sweep levels then 4 down-sweep levels, in place.
   // Each level only reads indices that the same level does not write.
   always_comb begin : prefix_core
      logic [W-1:0] gg;
      logic [W-1:0] pp;
      p     = core_x ^ core_y;
      gg    = core_x & core_y;
      pp    = p;
      gg[0] = gg[0] | (pp[0] & core_cin);

      for (int lv = 0; lv < 5; lv++) begin
         for (int i = (2 << lv) - 1; i < 32; i += (2 << lv)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << lv)]);
            pp[i] = pp[i] & pp[i - (1 << lv)];
         end
      end

      for (int lv = 3; lv >= 0; lv--) begin
         for (int i = 3 * (1 << lv) - 1; i < 32; i += (2 << lv)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << lv)]);
            pp[i] = pp[i] & pp[i - (1 << lv)];
         end
      end

      c = {gg, core_cin};
   end

   // Output register; reset wins over new data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s    <= '0;
         cout <= 1'b0;
      end else begin
         s    <= p ^ c[W-1:0];
         cout <= c[W];
      end
   end

endmodule

// File: tb/tb_brent_kung_adder32.sv
// Self-checking bench for brent_kung_adder32: directed, carry-chain, pipelined-reset and random vectors.
module tb_brent_kung_adder32;

`ifdef BK_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] x;
   logic [31:0] y;
   logic        cin;
   logic [31:0] s;
   logic        cout;

   int checks = 0;
   int errors = 0;

   // Expected results of past cycles, newest at the back
   logic [32:0] hist [$];

   brent_kung_adder32 dut (
      .clk  (clk),
      .rst_n(rst_n),
      .x    (x),
      .y    (y),
      .cin  (cin),
      .s    (s),
      .cout (cout)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus and return the output expected just after this edge.
   task automatic step(input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic rn, output logic [32:0] e);
      logic [32:0] v;
      @(negedge clk);
      x = a; y = b; cin = ci; rst_n = rn;
      v = rn ? ({1'b0, a} + {1'b0, b} + {32'd0, ci}) : 33'd0;
      hist.push_back(v);
      if (!rn)
         e = 33'd0;
      else if (hist.size() >= LAT)
         e = hist[hist.size() - LAT];
      else
         e = 33'd0;
      while (hist.size() > 4) void'(hist.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [32:0] e;
      for (int k = 0; k < 2; k++) begin
         step($urandom, $urandom, 1'($urandom), 1'b0, e);
         checks++;
         if ({cout, s} !== 33'd0) begin
            errors++;
            $display("FAIL reset[%0d]: got cout=%b s=%h, want cout=0 s=00000000", k, cout, s);
         end
      end
   endtask

   task automatic test_directed();
      logic [31:0] va [5];
      logic [31:0] vb [5];
      logic        vc [5];
      logic [32:0] want [5];
      logic [32:0] e;
      va[0] = 32'h42884743; vb[0] = 32'h42884743; vc[0] = 1'b0; want[0] = {1'b0, 32'h85108E86};
      va[1] = 32'hF28A47B3; vb[1] = 32'h4B8B47A3; vc[1] = 1'b1; want[1] = {1'b1, 32'h3E158F57};
      va[2] = 32'hF28E47BC; vb[2] = 32'h9B8B47AB; vc[2] = 1'b1; want[2] = {1'b1, 32'h8E198F68};
      va[3] = 32'h00000000; vb[3] = 32'h00000000; vc[3] = 1'b0; want[3] = 33'd0;
      va[4] = 32'hAAAAAAAA; vb[4] = 32'h55555555; vc[4] = 1'b1; want[4] = {1'b1, 32'h00000000};
      for (int k = 0; k < 5; k++) begin
         for (int r = 0; r < LAT; r++) step(va[k], vb[k], vc[k], 1'b1, e);
         checks++;
         if ({cout, s} !== want[k]) begin
            errors++;
            $display("FAIL directed[%0d]: got cout=%b s=%h, want cout=%b s=%h",
                     k, cout, s, want[k][32], want[k][31:0]);
         end
      end
   endtask

   task automatic test_carry_chain();
      logic [32:0] e;
      for (int r = 0; r < LAT; r++) step(32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, e);
      checks++;
      if ({cout, s} !== {1'b1, 32'h00000000}) begin
         errors++;
         $display("FAIL carry_full: got cout=%b s=%h, want cout=1 s=00000000", cout, s);
      end
      for (int r = 0; r < LAT; r++) step(32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, e);
      checks++;
      if ({cout, s} !== {1'b0, 32'h80000000}) begin
         errors++;
         $display("FAIL carry_msb: got cout=%b s=%h, want cout=0 s=80000000", cout, s);
      end
      // Single carry generated at each bit position must ripple to the top
      for (int b = 0; b < 32; b++) begin
         logic [31:0] a;
         a = 32'hFFFFFFFF << b;
         for (int r = 0; r < LAT; r++) step(a, 32'h1 << b, 1'b0, 1'b1, e);
         checks++;
         if ({cout, s} !== {1'b1, 32'h00000000}) begin
            errors++;
            $display("FAIL carry_bit[%0d]: got cout=%b s=%h, want cout=1 s=00000000", b, cout, s);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [32:0] e;
      for (int k = 0; k < 24; k++) begin
         logic rn;
         rn = (k == 11) ? 1'b0 : 1'b1;
         step($urandom, $urandom, 1'($urandom), rn, e);
         checks++;
         if ({cout, s} !== e) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got cout=%b s=%h, want cout=%b s=%h",
                     k, cout, s, e[32], e[31:0]);
         end
      end
   endtask

   task automatic test_random();
      logic [32:0] e;
      for (int k = 0; k < 10000; k++) begin
         step($urandom, $urandom, 1'($urandom), 1'b1, e);
         checks++;
         if ({cout, s} !== e) begin
            errors++;
            if (errors < 20)
               $display("FAIL random[%0d]: got cout=%b s=%h, want cout=%b s=%h",
                        k, cout, s, e[32], e[31:0]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      x     = '0;
      y     = '0;
      cin   = 1'b0;
      test_reset();
      test_directed();
      test_carry_chain();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
